// File: rtl/regfile_write_queue.sv
// Write queue in front of the 32x32 register file: buffers writebacks, drains one per cycle,
// and offers newest-entry bypass to decode. Define WQ_STALL_CNT_EN to add the stall counter.
module regfile_write_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 5,
    parameter int unsigned DW    = 32
) (
    input  logic                       CLOCK,
    input  logic                       RESET,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [AW-1:0]              in_addr,
    input  logic [DW-1:0]              in_data,
    input  logic                       drain_en,
    output logic                       wr_en,
    output logic [AW-1:0]              wr_addr,
    output logic [DW-1:0]              wr_data,
    input  logic [AW-1:0]              rd_addr1,
    input  logic [AW-1:0]              rd_addr2,
    output logic                       fwd_hit1,
    output logic [DW-1:0]              fwd_data1,
    output logic                       fwd_hit2,
    output logic [DW-1:0]              fwd_data2,
    output logic [$clog2(DEPTH):0]     occupancy
`ifdef WQ_STALL_CNT_EN
    ,
    output logic [15:0]                stall_cycles
`endif
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [AW-1:0] addr_q [DEPTH];
    logic [DW-1:0] data_q [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic push;
    logic pop;
    logic [PW-1:0] idx;

    always_comb begin
        in_ready = (count_q < CW'(DEPTH));
        // Writes to r0 complete the handshake but are never stored.
        push     = in_valid && in_ready && (in_addr != '0);
        pop      = (count_q != '0) && drain_en;
        head_d   = pop  ? head_q + 1'b1 : head_q;
        tail_d   = push ? tail_q + 1'b1 : tail_q;
        count_d  = count_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            if (push) begin
                addr_q[tail_q] <= in_addr;
                data_q[tail_q] <= in_data;
            end
        end
    end

    always_comb begin
        wr_en     = pop;
        wr_addr   = (count_q != '0) ? addr_q[head_q] : '0;
        wr_data   = (count_q != '0) ? data_q[head_q] : '0;
        occupancy = count_q;
    end

    // Scan oldest to newest so the last match, closest to tail, wins.
    always_comb begin
        fwd_hit1  = 1'b0;
        fwd_data1 = '0;
        fwd_hit2  = 1'b0;
        fwd_data2 = '0;
        idx       = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = head_q + PW'(i);
            if (CW'(i) < count_q) begin
                if ((rd_addr1 != '0) && (addr_q[idx] == rd_addr1)) begin
                    fwd_hit1  = 1'b1;
                    fwd_data1 = data_q[idx];
                end
                if ((rd_addr2 != '0) && (addr_q[idx] == rd_addr2)) begin
                    fwd_hit2  = 1'b1;
                    fwd_data2 = data_q[idx];
                end
            end
        end
    end

`ifdef WQ_STALL_CNT_EN
    logic [15:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (in_valid && !in_ready && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_regfile_write_queue.sv
// Directed self-checking bench for regfile_write_queue at DEPTH=4.
// Covers reset, latency, fill/drain, bypass, r0 discard, wrap, and the optional stall counter.
module tb_regfile_write_queue;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned AW    = 5;
    localparam int unsigned DW    = 32;

    logic          CLOCK = 1'b0;
    logic          RESET;
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] in_addr;
    logic [DW-1:0] in_data;
    logic          drain_en;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [AW-1:0] rd_addr1;
    logic [AW-1:0] rd_addr2;
    logic          fwd_hit1;
    logic [DW-1:0] fwd_data1;
    logic          fwd_hit2;
    logic [DW-1:0] fwd_data2;
    logic [2:0]    occupancy;
`ifdef WQ_STALL_CNT_EN
    logic [15:0]   stall_cycles;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 CLOCK = ~CLOCK;

    regfile_write_queue #(
        .DEPTH(DEPTH),
        .AW   (AW),
        .DW   (DW)
    ) u_dut (
        .CLOCK       (CLOCK),
        .RESET       (RESET),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_addr     (in_addr),
        .in_data     (in_data),
        .drain_en    (drain_en),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .rd_addr1    (rd_addr1),
        .rd_addr2    (rd_addr2),
        .fwd_hit1    (fwd_hit1),
        .fwd_data1   (fwd_data1),
        .fwd_hit2    (fwd_hit2),
        .fwd_data2   (fwd_data2),
        .occupancy   (occupancy)
`ifdef WQ_STALL_CNT_EN
        ,
        .stall_cycles(stall_cycles)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge CLOCK);
        #1;
    endtask

    // Present one request for a single edge, then drop valid.
    task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d);
        in_valid = 1'b1;
        in_addr  = a;
        in_data  = d;
        step();
        in_valid = 1'b0;
        in_addr  = '0;
        in_data  = '0;
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        #1;
        step();
        RESET = 1'b0;
        #1;
    endtask

    initial begin
        RESET    = 1'b1;
        in_valid = 1'b0;
        in_addr  = '0;
        in_data  = '0;
        drain_en = 1'b0;
        rd_addr1 = '0;
        rd_addr2 = '0;
        #1;
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        check_eq("rst_occupancy", 32'(occupancy), 32'd0);
        check_eq("rst_wr_addr", 32'(wr_addr), 32'd0);
        step();
        RESET = 1'b0;
        #1;

        // 1: reset mid-operation with 3 queued entries
        push(5'd1, 32'hA1);
        push(5'd2, 32'hA2);
        push(5'd3, 32'hA3);
        check_eq("t1_occ3", 32'(occupancy), 32'd3);
        drain_en = 1'b1;
        rd_addr1 = 5'd1;
        #1;
        check_eq("t1_wr_en_pre", 32'(wr_en), 32'd1);
        check_eq("t1_hit_pre", 32'(fwd_hit1), 32'd1);
        #2;
        RESET = 1'b1;
        #1;
        check_eq("t1_rst_wr_en", 32'(wr_en), 32'd0);
        check_eq("t1_rst_occ", 32'(occupancy), 32'd0);
        check_eq("t1_rst_in_ready", 32'(in_ready), 32'd1);
        check_eq("t1_rst_fwd_hit1", 32'(fwd_hit1), 32'd0);
        check_eq("t1_rst_wr_data", 32'(wr_data), 32'd0);
        step();
        RESET = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            check_eq("t1_no_write", 32'(wr_en), 32'd0);
            step();
        end
        rd_addr1 = '0;

        // 2: single write with drain enabled
        drain_en = 1'b1;
        push(5'd5, 32'hDEADBEEF);
        check_eq("t2_wr_en", 32'(wr_en), 32'd1);
        check_eq("t2_wr_addr", 32'(wr_addr), 32'd5);
        check_eq("t2_wr_data", wr_data, 32'hDEADBEEF);
        step();
        check_eq("t2_occ0", 32'(occupancy), 32'd0);
        check_eq("t2_wr_en_off", 32'(wr_en), 32'd0);

        // 3: fill, refuse fifth, then drain in order
        drain_en = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            push(AW'(i), 32'(i * 10));
        end
        check_eq("t3_in_ready", 32'(in_ready), 32'd0);
        check_eq("t3_occ4", 32'(occupancy), 32'd4);
        push(5'd9, 32'd90);
        check_eq("t3_refused_occ", 32'(occupancy), 32'd4);
        drain_en = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            #1;
            check_eq("t3_wr_en", 32'(wr_en), 32'd1);
            check_eq("t3_wr_addr", 32'(wr_addr), 32'(i));
            check_eq("t3_wr_data", wr_data, 32'(i * 10));
            step();
        end
        check_eq("t3_wr_en_done", 32'(wr_en), 32'd0);
        check_eq("t3_occ_done", 32'(occupancy), 32'd0);

        // 4: bypass returns the newest matching entry
        drain_en = 1'b0;
        push(5'd7, 32'h11);
        push(5'd7, 32'h22);
        rd_addr1 = 5'd7;
        rd_addr2 = 5'd0;
        in_valid = 1'b1;
        in_addr  = 5'd0;
        #1;
        check_eq("t4_hit1", 32'(fwd_hit1), 32'd1);
        check_eq("t4_data1", fwd_data1, 32'h22);
        check_eq("t4_hit2", 32'(fwd_hit2), 32'd0);
        check_eq("t4_data2", fwd_data2, 32'd0);
        in_valid = 1'b0;
        rd_addr2 = 5'd8;
        in_addr  = 5'd8;
        in_data  = 32'h33;
        in_valid = 1'b1;
        #1;
        check_eq("t4_incoming_no_hit", 32'(fwd_hit2), 32'd0);
        in_valid = 1'b0;
        drain_en = 1'b1;
        #1;
        check_eq("t4_head_pop_hit", 32'(fwd_hit1), 32'd1);
        check_eq("t4_head_pop_data", fwd_data1, 32'h22);
        step();
        check_eq("t4_last_data", fwd_data1, 32'h22);
        step();
        check_eq("t4_drained_hit", 32'(fwd_hit1), 32'd0);
        rd_addr1 = '0;
        rd_addr2 = '0;

        // 5a: writes to r0 are dropped
        check_eq("t5_r0_ready", 32'(in_ready), 32'd1);
        push(5'd0, 32'hFFFF);
        check_eq("t5_r0_occ", 32'(occupancy), 32'd0);
        check_eq("t5_r0_wr_en", 32'(wr_en), 32'd0);

        // 5b: two prefilled, then stream 8 more with simultaneous pops across wrap
        drain_en = 1'b0;
        push(5'd1, 32'd101);
        push(5'd2, 32'd102);
        drain_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i + 3 <= 10) begin
                in_valid = 1'b1;
                in_addr  = AW'(i + 3);
                in_data  = 32'(100 + i + 3);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            check_eq("t5_wrap_addr", 32'(wr_addr), 32'(i + 1));
            check_eq("t5_wrap_data", wr_data, 32'(100 + i + 1));
            step();
        end
        in_valid = 1'b0;
        #1;
        check_eq("t5_wrap_wr_en", 32'(wr_en), 32'd0);
        check_eq("t5_wrap_occ", 32'(occupancy), 32'd0);

`ifdef WQ_STALL_CNT_EN
        // 6: stall counter counts refused cycles
        do_reset();
        check_eq("t6_cleared", 32'(stall_cycles), 32'd0);
        drain_en = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            push(AW'(i), 32'(i));
        end
        in_valid = 1'b1;
        in_addr  = 5'd6;
        in_data  = 32'd6;
        for (int i = 0; i < 5; i++) begin
            step();
        end
        in_valid = 1'b0;
        #1;
        check_eq("t6_stall5", 32'(stall_cycles), 32'd5);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
